// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the receiver-facing capture inputs and the
// consumer-facing read/status signals of the UART receive FIFO.
//   master: drives rx_data/rx_data_ready/rx_error, rd_en, ovf_clr;
//           observes rd_data, rd_err, empty, full, count, overflow.
//   slave : the FIFO side (directions mirrored).
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          rx_data;
  logic                rx_data_ready;
  logic                rx_error;
  logic                rd_en;
  logic                ovf_clr;
  logic [7:0]          rd_data;
  logic                rd_err;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output rx_data, rx_data_ready, rx_error, rd_en, ovf_clr,
    input  rd_data, rd_err, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_data_ready, rx_error, rd_en, ovf_clr,
    output rd_data, rd_err, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind a UART receiver.
// Synchronises the asynchronous rx_data_ready level, turns each rising
// level into one push of {rx_error, rx_data}, and holds the entries in a
// first-word-fall-through FIFO drained by rd_en.
// Ports:
//   clk   - system clock, all state on its rising edge
//   rst_n - synchronous active-low reset
//   bus   - uart_rx_fifo_if.slave: rx_data/rx_data_ready/rx_error capture
//           inputs, rd_en pop strobe, ovf_clr, and rd_data/rd_err head
//           entry plus empty/full/count/overflow status.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter bit DROP_ERRORED = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [2:0]            sync_pipe;   // [0]=s1, [1]=s2, [2]=s3
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt, cnt_nxt;
  logic                  empty_q, full_q, ovf_q;
  logic                  push_req, wr_req, wr_en, pop, drop;
  entry_t                head;

  // Rising edge of the synchronised ready level; s1..s3 reset high so a
  // ready level left high across reset never looks like a new frame.
  assign push_req = sync_pipe[1] & ~sync_pipe[2];
  assign wr_req   = push_req & ~(DROP_ERRORED & bus.rx_error);
  assign pop      = bus.rd_en & ~empty_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = wr_req & (~full_q | pop);
  assign drop     = wr_req & full_q & ~pop;

  always_comb begin
    cnt_nxt = cnt;
    unique case ({wr_en, pop})
      2'b10:   cnt_nxt = cnt + CNT_ONE;
      2'b01:   cnt_nxt = cnt - CNT_ONE;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe <= 3'b111;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], bus.rx_data_ready};
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      cnt     <= cnt_nxt;
      empty_q <= (cnt_nxt == '0);
      full_q  <= (cnt_nxt == CNT_MAX);
      // set beats clear when both land together
      if (drop)             ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[wr_ptr] <= '{err: bus.rx_error, data: bus.rx_data};
  end

  assign head         = mem[rd_ptr];
  assign bus.rd_data  = empty_q ? 8'h00 : head.data;
  assign bus.rd_err   = empty_q ? 1'b0  : head.err;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = cnt;
  assign bus.overflow = ovf_q;
endmodule
